// File: rtl/my_skid_rr_arb_pkg.sv
// Shared definitions for the round-robin packet arbiter: FSM state encoding
// and the bit layout of the {last, id, data} word carried by the skid stage.
package my_skid_rr_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int LAST_W = 1;

    // Total width of one packed beat: data, then id, then the last flag on top.
    function automatic int payload_width(input int dw, input int iw);
        return dw + iw + LAST_W;
    endfunction

    // Bit position where the requester id starts inside a packed beat.
    function automatic int id_lsb(input int dw);
        return dw;
    endfunction

    // Bit position of the end-of-packet flag inside a packed beat.
    function automatic int last_bit(input int dw, input int iw);
        return dw + iw;
    endfunction

endpackage

// File: rtl/my_skid.sv
// Two-entry skid buffer: a registered output slot plus one overflow slot.
// o_ready depends only on local state, so the downstream ready path is cut.
module my_skid #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic         buf_valid_q, buf_valid_d;
    logic [W-1:0] buf_data_q,  buf_data_d;
    logic         in_fire_s;
    logic         out_free_s;

    assign o_ready    = ~buf_valid_q;
    assign o_valid    = out_valid_q;
    assign o_data     = out_data_q;
    assign in_fire_s  = i_valid & ~buf_valid_q;
    assign out_free_s = ~out_valid_q | i_ready;

    // Next-state: refill the output slot from the overflow slot first, else from the input.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        if (out_free_s) begin
            if (buf_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = buf_data_q;
                buf_valid_d = 1'b0;
            end else if (in_fire_s) begin
                out_valid_d = 1'b1;
                out_data_d  = i_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (in_fire_s) begin
                buf_valid_d = 1'b1;
                buf_data_d  = i_data;
            end else begin
                buf_valid_d = buf_valid_q;
            end
        end
    end

    // State registers; reset empties both slots and clears the visible payload.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {W{1'b0}};
            buf_valid_q <= 1'b0;
            buf_data_q  <= {W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
        end
    end

endmodule

// File: rtl/my_skid_rr_arb.sv
// Round-robin packet arbiter: grants one requester for a whole packet and
// forwards its beats, tagged with the requester id, through a skid stage.
module my_skid_rr_arb
    import my_skid_rr_arb_pkg::*;
#(
    parameter  int DW = 8,
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [N-1:0]    i_valid,
    input  logic [N*DW-1:0] i_data,
    input  logic [N-1:0]    i_last,
    output logic [N-1:0]    o_ready,
    output logic            o_valid,
    output logic [DW-1:0]   o_data,
    output logic            o_last,
    output logic [IW-1:0]   o_id,
    input  logic            i_ready
);

    localparam int PW       = payload_width(DW, IW);
    localparam int ID_LSB   = id_lsb(DW);
    localparam int LAST_BIT = last_bit(DW, IW);

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  gnt_q,   gnt_d;
    logic [IW-1:0]  ptr_q,   ptr_d;

    logic           pick_any_s;
    logic [IW-1:0]  pick_idx_s;
    logic           push_valid_s;
    logic           beat_fire_s;
    logic           skid_ready_s;
    logic [PW-1:0]  push_data_s;
    logic [PW-1:0]  skid_data_s;
    logic [DW-1:0]  data_arr_s [N];

    for (genvar g = 0; g < N; g++) begin : g_split
        assign data_arr_s[g] = i_data[g*DW +: DW];
    end

    assign beat_fire_s = push_valid_s & skid_ready_s;
    assign push_data_s = {i_last[gnt_q], gnt_q, data_arr_s[gnt_q]};

    // Round-robin pick: first valid requester after the last-served one, wrapping at N.
    always_comb begin
        logic [IW-1:0] cand_v;
        pick_any_s = 1'b0;
        pick_idx_s = {IW{1'b0}};
        cand_v     = {IW{1'b0}};
        for (int i = 1; i <= N; i++) begin
            cand_v = IW'((int'(ptr_q) + i) % N);
            if (!pick_any_s && i_valid[cand_v]) begin
                pick_any_s = 1'b1;
                pick_idx_s = cand_v;
            end else begin
                pick_any_s = pick_any_s;
            end
        end
    end

    // FSM state register; reset makes requester 0 the first winner.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= {IW{1'b0}};
            ptr_q   <= IW'(N - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // FSM next state: grant in IDLE, release and remember the winner on the last beat.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_d = ST_BUSY;
                    gnt_d   = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (beat_fire_s && i_last[gnt_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = gnt_q;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: only the granted requester sees ready, and only while BUSY.
    always_comb begin
        o_ready      = {N{1'b0}};
        push_valid_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_ready      = {N{1'b0}};
                push_valid_s = 1'b0;
            end
            ST_BUSY: begin
                o_ready[gnt_q] = skid_ready_s;
                push_valid_s   = i_valid[gnt_q];
            end
            default: begin
                o_ready      = {N{1'b0}};
                push_valid_s = 1'b0;
            end
        endcase
    end

    my_skid #(
        .W (PW)
    ) u_skid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (push_valid_s),
        .o_ready (skid_ready_s),
        .i_data  (push_data_s),
        .o_valid (o_valid),
        .o_data  (skid_data_s),
        .i_ready (i_ready)
    );

    assign o_data = skid_data_s[DW-1:0];
    assign o_id   = skid_data_s[ID_LSB +: IW];
    assign o_last = skid_data_s[LAST_BIT];

endmodule

// File: tb/tb_my_skid_rr_arb.sv
// Directed self-checking bench for my_skid_rr_arb (N=4, DW=8).
module tb_my_skid_rr_arb;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [3:0]  i_valid = 4'd0;
    logic [31:0] i_data = 32'd0;
    logic [3:0]  i_last = 4'd0;
    logic [3:0]  o_ready;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        o_last;
    logic [1:0]  o_id;
    logic        i_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    // Requester model: each requester sends beats base+sent, packets of plen beats.
    int sent[4];
    int target[4];
    int plen[4];
    int base[4];
    bit hold[4];

    int q_data[$];
    int q_id[$];
    int q_last[$];
    int q_cyc[$];
    int cyc = 0;
    logic [3:0]  last_rdy;
    bit          stall_q = 1'b0;
    logic [11:0] stall_snap;

    my_skid_rr_arb #(.DW(8), .N(4)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_id    (o_id),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            sent[k] = 0; target[k] = 0; plen[k] = 1; base[k] = 0; hold[k] = 1'b0;
        end
        q_data.delete(); q_id.delete(); q_last.delete(); q_cyc.delete();
    endtask

    task automatic drive();
        logic [7:0] d [4];
        logic [3:0] v;
        logic [3:0] l;
        v = 4'd0;
        l = 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (sent[k] < target[k] && !hold[k]) v = v | (4'd1 << k);
            if ((sent[k] % plen[k]) == plen[k] - 1) l = l | (4'd1 << k);
            d[k] = 8'(base[k] + sent[k]);
        end
        i_valid = v;
        i_last  = l;
        i_data  = {d[3], d[2], d[1], d[0]};
    endtask

    // One clock cycle: drive, sample mid-cycle, record accepted output beats, advance.
    task automatic cycle();
        logic [3:0] hs;
        drive();
        #1;
        last_rdy = o_ready;
        if (stall_q) chk("stall_hold", 32'({o_valid, o_last, o_id, o_data}), 32'(stall_snap));
        stall_q    = o_valid && !i_ready;
        stall_snap = {o_valid, o_last, o_id, o_data};
        if (o_valid && i_ready) begin
            q_data.push_back(int'(o_data));
            q_id.push_back(int'(o_id));
            q_last.push_back(int'(o_last));
            q_cyc.push_back(cyc);
        end
        hs = i_valid & o_ready;
        step();
        cyc++;
        for (int k = 0; k < 4; k++) begin
            if (((hs >> k) & 4'd1) != 4'd0) sent[k]++;
        end
    endtask

    task automatic exp_beat(input string tag, input int i, input int d, input int id, input int l);
        if (i < q_data.size()) begin
            chk({tag, "_data"}, 32'(q_data[i]), 32'(d));
            chk({tag, "_id"},   32'(q_id[i]),   32'(id));
            chk({tag, "_last"}, 32'(q_last[i]), 32'(l));
        end else begin
            chk({tag, "_missing"}, 32'(q_data.size()), 32'(i + 1));
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_ready = 1'b1;
        clear_model();
        drive();
        step();
        step();
        i_reset = 1'b0;
        stall_q = 1'b0;
    endtask

    initial begin
        int exp_d;
        int p;
        clear_model();

        // ---- T1: reset values, then a single beat 0xA5 from requester 0
        do_reset();
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_last",  32'(o_last),  32'd0);
        chk("rst_id",    32'(o_id),    32'd0);
        chk("rst_data",  32'(o_data),  32'd0);
        target[0] = 1; base[0] = 8'hA5;
        drive();
        #1;
        chk("t1_c0_ready", 32'(o_ready), 32'd0);
        step();
        chk("t1_c1_ready", 32'(o_ready), 32'b0001);
        step();
        sent[0] = 1;
        drive();
        #1;
        chk("t1_c2_valid", 32'(o_valid), 32'd1);
        chk("t1_c2_data",  32'(o_data),  32'hA5);
        chk("t1_c2_id",    32'(o_id),    32'd0);
        chk("t1_c2_last",  32'(o_last),  32'd1);
        step();
        chk("t1_c3_valid", 32'(o_valid), 32'd0);

        // ---- T2: all four requesters, two 2-beat packets each
        do_reset();
        for (int k = 0; k < 4; k++) begin
            target[k] = 4; plen[k] = 2; base[k] = k * 16;
        end
        for (int c = 0; c < 40; c++) cycle();
        chk("t2_count", 32'(q_data.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            p = i / 2;
            exp_d = (p % 4) * 16 + (p / 4) * 2 + (i % 2);
            exp_beat("t2", i, exp_d, p % 4, i % 2);
            if (i > 0 && i < q_cyc.size())
                chk("t2_gap", 32'(q_cyc[i] - q_cyc[i-1]), (i % 2 == 1) ? 32'd1 : 32'd2);
        end

        // ---- T3: requester 2, 3-beat packet, downstream ready 1,0,0 repeating
        clear_model();
        target[2] = 3; plen[2] = 3; base[2] = 8'h10;
        for (int c = 0; c < 30; c++) begin
            i_ready = (c % 3 == 0);
            cycle();
        end
        i_ready = 1'b1;
        cycle();
        chk("t3_count", 32'(q_data.size()), 32'd3);
        exp_beat("t3_b0", 0, 8'h10, 2, 0);
        exp_beat("t3_b1", 1, 8'h11, 2, 0);
        exp_beat("t3_b2", 2, 8'h12, 2, 1);

        // ---- T4: requester 1 stalls mid-packet while requester 3 waits
        clear_model();
        target[1] = 3; plen[1] = 3; base[1] = 8'h40;
        for (int c = 0; c < 10 && sent[1] < 1; c++) cycle();
        chk("t4_first_beat", 32'(sent[1]), 32'd1);
        hold[1] = 1'b1;
        target[3] = 1; base[3] = 8'h70;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("t4_hold_ready", 32'(last_rdy), 32'b0010);
        end
        hold[1] = 1'b0;
        for (int c = 0; c < 15; c++) cycle();
        chk("t4_count", 32'(q_data.size()), 32'd4);
        exp_beat("t4_b0", 0, 8'h40, 1, 0);
        exp_beat("t4_b1", 1, 8'h41, 1, 0);
        exp_beat("t4_b2", 2, 8'h42, 1, 1);
        exp_beat("t4_b3", 3, 8'h70, 3, 1);

        // ---- T5: reset during beat 2 of a 4-beat packet with the skid stage full
        clear_model();
        i_ready = 1'b0;
        target[0] = 4; plen[0] = 4; base[0] = 8'h50;
        for (int c = 0; c < 10 && sent[0] < 2; c++) cycle();
        chk("t5_fill", 32'(sent[0]), 32'd2);
        drive();
        #1;
        chk("t5_skid_full_ready", 32'(o_ready), 32'd0);
        i_reset = 1'b1;
        step();
        chk("t5_rst_valid", 32'(o_valid), 32'd0);
        chk("t5_rst_ready", 32'(o_ready), 32'd0);
        i_reset = 1'b0;
        stall_q = 1'b0;
        i_ready = 1'b1;
        clear_model();
        for (int k = 0; k < 4; k++) begin
            target[k] = 1; base[k] = k * 16 + 8;
        end
        for (int c = 0; c < 15; c++) cycle();
        chk("t5_count", 32'(q_data.size()), 32'd4);
        for (int i = 0; i < 4; i++) exp_beat("t5", i, i * 16 + 8, i, 1);

        // ---- T6: only requester 3, repeated single-beat packets
        clear_model();
        target[3] = 4; base[3] = 8'h30;
        for (int c = 0; c < 14; c++) cycle();
        chk("t6_count", 32'(q_data.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            exp_beat("t6", i, 8'h30 + i, 3, 1);
            if (i > 0 && i < q_cyc.size())
                chk("t6_gap", 32'(q_cyc[i] - q_cyc[i-1]), 32'd2);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
